dcache_ctrl: RTL and testbench

Data-cache controller on the memory-stage side of the pipeline register. It consumes MemRead/MemWrite, address and store data, returns load data, and drives the stall ("hold") to all pipeline registers. Direct-mapped, write-back, write-allocate, 32-byte lines. On a miss it runs a request/ack handshake with a slow 256-bit main memory.

---
 rtl/dcache_pkg.sv | 19 +
 rtl/dcache_sram.sv | 56 +++++
 rtl/dcache_ctrl.sv | 137 +++++++++++++
 tb/tb_dcache_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned LINE_W         = 256;
  localparam int unsigned OFFSET_W       = 5;
  localparam int unsigned WORDS_PER_LINE = 8;

  typedef enum logic [1:0] {StIdle, StWb, StRf} state_e;

  function automatic int unsigned idx_width(int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int unsigned tag_width(int unsigned num_lines);
    return ADDR_W - OFFSET_W - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data arrays: combinational read by index, synchronous line or word write.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int unsigned NumLines = 32,
  parameter int unsigned IdxW     = idx_width(NumLines),
  parameter int unsigned TagW     = tag_width(NumLines)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IdxW-1:0]   idx_i,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [TagW-1:0]   tag_o,
  output logic [LINE_W-1:0] line_o,
  input  logic              line_we_i,
  input  logic [TagW-1:0]   line_tag_i,
  input  logic [LINE_W-1:0] line_data_i,
  input  logic              word_we_i,
  input  logic [2:0]        word_sel_i,
  input  logic [31:0]       word_data_i
);

  logic [LINE_W-1:0]   data_q [NumLines];
  logic [TagW-1:0]     tag_q  [NumLines];
  logic [NumLines-1:0] valid_q;
  logic [NumLines-1:0] dirty_q;

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; valid gates every use of them.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      data_q[idx_i] <= line_data_i;
      tag_q[idx_i]  <= line_tag_i;
    end else if (word_we_i) begin
      data_q[idx_i][{word_sel_i, 5'b0} +: 32] <= word_data_i;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller with line-memory handshake.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned NumLines = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_rd_i,
  input  logic              cpu_wr_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int unsigned IdxW = idx_width(NumLines);
  localparam int unsigned TagW = tag_width(NumLines);

  state_e            state_q;
  logic [TagW-1:0]   req_tag_q;
  logic [IdxW-1:0]   req_idx_q;
  logic              mem_enable_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic [TagW-1:0]   cpu_tag;
  logic [IdxW-1:0]   cpu_idx;
  logic [2:0]        word_sel;
  logic              unused_byte_sel;

  logic [IdxW-1:0]   sram_idx;
  logic              sram_valid;
  logic              sram_dirty;
  logic [TagW-1:0]   sram_tag;
  logic [LINE_W-1:0] sram_line;

  logic is_idle, req, hit, miss, word_we, line_we;

  assign cpu_tag         = cpu_addr_i[ADDR_W-1 -: TagW];
  assign cpu_idx         = cpu_addr_i[OFFSET_W +: IdxW];
  assign word_sel        = cpu_addr_i[4:2];
  assign unused_byte_sel = ^cpu_addr_i[1:0];

  assign is_idle  = (state_q == StIdle);
  assign req      = cpu_rd_i | cpu_wr_i;
  // Outside IDLE the arrays are addressed by the latched request, never by live CPU inputs.
  assign sram_idx = is_idle ? cpu_idx : req_idx_q;
  assign hit      = is_idle & sram_valid & (sram_tag == cpu_tag);
  assign miss     = is_idle & req & ~hit;
  assign word_we  = hit & cpu_wr_i;
  assign line_we  = (state_q == StRf) & mem_ack_i;

  dcache_sram #(
    .NumLines (NumLines)
  ) u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (sram_idx),
    .valid_o     (sram_valid),
    .dirty_o     (sram_dirty),
    .tag_o       (sram_tag),
    .line_o      (sram_line),
    .line_we_i   (line_we),
    .line_tag_i  (req_tag_q),
    .line_data_i (mem_data_i),
    .word_we_i   (word_we),
    .word_sel_i  (word_sel),
    .word_data_i (cpu_data_i)
  );

  // Combinational outputs are gated by reset so every output reads 0 while held in reset.
  assign cpu_stall_o  = rst_i & (~is_idle | miss);
  assign cpu_data_o   = (rst_i & hit & cpu_rd_i & ~cpu_wr_i) ?
                        sram_line[{word_sel, 5'b0} +: 32] : '0;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = (state_q == StWb) ? sram_line : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      req_tag_q    <= '0;
      req_idx_q    <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (miss) begin
            req_tag_q    <= cpu_tag;
            req_idx_q    <= cpu_idx;
            mem_enable_q <= 1'b1;
            if (sram_valid && sram_dirty) begin
              state_q     <= StWb;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {sram_tag, cpu_idx, {OFFSET_W{1'b0}}};
            end else begin
              state_q     <= StRf;
              mem_write_q <= 1'b0;
              mem_addr_q  <= {cpu_tag, cpu_idx, {OFFSET_W{1'b0}}};
            end
          end
        end
        StWb: begin
          if (mem_ack_i) begin
            state_q     <= StRf;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {req_tag_q, req_idx_q, {OFFSET_W{1'b0}}};
          end
        end
        StRf: begin
          if (mem_ack_i) begin
            state_q      <= StIdle;
            mem_enable_q <= 1'b0;
            mem_addr_q   <= '0;
          end
        end
        default: begin
          state_q      <= StIdle;
          mem_enable_q <= 1'b0;
          mem_write_q  <= 1'b0;
          mem_addr_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed table, reset-abort sequence, randomized model check.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_rd_i, cpu_wr_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o, mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;

  always #5 clk_i = ~clk_i;

  dcache_ctrl #(
    .NumLines (32)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cpu_rd_i     (cpu_rd_i),
    .cpu_wr_i     (cpu_wr_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_data_i   (cpu_data_i),
    .cpu_data_o   (cpu_data_o),
    .cpu_stall_o  (cpu_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
    logic [31:0] data;
    int          ntx;
    logic [31:0] wb_addr;
    int          wb_w;
    logic [31:0] wb_word;
    logic [31:0] rf_addr;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int lat   = 3;

  logic [255:0] phys_mem [logic [31:0]];
  logic [255:0] ref_mem  [logic [31:0]];
  txn_t         txn_q[$];
  txn_t         exp_q[$];

  bit           m_valid [32];
  bit           m_dirty [32];
  logic [21:0]  m_tag   [32];
  logic [255:0] m_data  [32];

  function automatic logic [255:0] init_line(logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = la ^ (32'(w) * 32'h0101_0101) ^ 32'hA500_0000;
    return l;
  endfunction

  function automatic logic [255:0] phys_get(logic [31:0] la);
    return phys_mem.exists(la) ? phys_mem[la] : init_line(la);
  endfunction

  function automatic logic [255:0] ref_get(logic [31:0] la);
    return ref_mem.exists(la) ? ref_mem[la] : init_line(la);
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Slow line memory: acks `lat` cycles after a request is seen, logs each completed transfer.
  initial begin
    int cnt;
    cnt        = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      mem_ack_i = 1'b0;
      if (!rst_i || !mem_enable_o) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt >= lat) begin
          cnt       = 0;
          mem_ack_i = 1'b1;
          if (mem_write_o) phys_mem[mem_addr_o] = mem_data_o;
          else mem_data_i = phys_get(mem_addr_o);
          txn_q.push_back('{mem_write_o, mem_addr_o, mem_data_o});
        end
      end
    end
  end

  // Called just after a negedge; returns stalled cycles and load data seen when stall drops.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, output int cyc, output logic [31:0] rdata);
    txn_q.delete();
    cpu_rd_i   = rd;
    cpu_wr_i   = wr;
    cpu_addr_i = addr;
    cpu_data_i = wdata;
    #1;
    cyc = 0;
    while (cpu_stall_o !== 1'b0 && cyc < 100) begin
      @(negedge clk_i);
      #1;
      cyc++;
    end
    rdata = cpu_data_o;
    @(negedge clk_i);
    cpu_rd_i = 1'b0;
    cpu_wr_i = 1'b0;
  endtask

  task automatic model_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              output int cyc, output logic [31:0] data);
    int          idx;
    int          w;
    logic [21:0] tag;
    logic [31:0] la;
    idx = int'(addr[9:5]);
    w   = int'(addr[4:2]);
    tag = addr[31:10];
    exp_q.delete();
    cyc = 0;
    if (!(m_valid[idx] && m_tag[idx] == tag)) begin
      cyc = 1 + lat;
      if (m_valid[idx] && m_dirty[idx]) begin
        la          = {m_tag[idx], 5'(idx), 5'b0};
        ref_mem[la] = m_data[idx];
        exp_q.push_back('{1'b1, la, m_data[idx]});
        cyc += lat;
      end
      la = {tag, 5'(idx), 5'b0};
      exp_q.push_back('{1'b0, la, 256'b0});
      m_data[idx]  = ref_get(la);
      m_tag[idx]   = tag;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      m_data[idx][w*32 +: 32] = wdata;
      m_dirty[idx]            = 1'b1;
      data                    = '0;
    end else begin
      data = m_data[idx][w*32 +: 32];
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t         tbl [8];
    int           cyc, exp_cyc, op;
    logic [31:0]  rdata, exp_data, addr, wdata;
    logic [255:0] line;
    logic         rd, wr;

    tbl[0] = '{1'b1, 1'b0, 32'h104, 32'h0,        4, 32'hDEAD_BEEF, 1, 32'h0,   0, 32'h0,        32'h100};
    tbl[1] = '{1'b0, 1'b1, 32'h108, 32'h1234_5678, 0, 32'h0,        0, 32'h0,   0, 32'h0,        32'h0};
    tbl[2] = '{1'b1, 1'b0, 32'h108, 32'h0,        0, 32'h1234_5678, 0, 32'h0,   0, 32'h0,        32'h0};
    tbl[3] = '{1'b1, 1'b0, 32'h500, 32'h0,        7, 32'hA500_0500, 2, 32'h100, 2, 32'h1234_5678, 32'h500};
    tbl[4] = '{1'b1, 1'b0, 32'h100, 32'h0,        4, 32'hA500_0100, 1, 32'h0,   0, 32'h0,        32'h100};
    tbl[5] = '{1'b1, 1'b1, 32'h104, 32'hAAAA_5555, 0, 32'h0,        0, 32'h0,   0, 32'h0,        32'h0};
    tbl[6] = '{1'b1, 1'b0, 32'h504, 32'h0,        7, 32'hA401_0401, 2, 32'h100, 1, 32'hAAAA_5555, 32'h500};
    tbl[7] = '{1'b1, 1'b0, 32'h104, 32'h0,        4, 32'hAAAA_5555, 1, 32'h0,   0, 32'h0,        32'h100};

    line              = init_line(32'h100);
    line[63:32]       = 32'hDEAD_BEEF;
    phys_mem[32'h100] = line;

    // Reset with a live request: every output must still read 0.
    rst_i      = 1'b0;
    cpu_rd_i   = 1'b1;
    cpu_wr_i   = 1'b0;
    cpu_addr_i = 32'h104;
    cpu_data_i = '0;
    #1;
    check("rst stall", 256'(cpu_stall_o), 256'(0));
    check("rst data", 256'(cpu_data_o), 256'(0));
    check("rst enable", 256'(mem_enable_o), 256'(0));
    check("rst write", 256'(mem_write_o), 256'(0));
    check("rst addr", 256'(mem_addr_o), 256'(0));
    check("rst mdata", mem_data_o, 256'(0));
    cpu_rd_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 8; i++) begin
      lat = 3;
      do_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, cyc, rdata);
      check($sformatf("tbl%0d stall cycles", i), 256'(cyc), 256'(tbl[i].cyc));
      check($sformatf("tbl%0d load data", i), 256'(rdata), 256'(tbl[i].data));
      check($sformatf("tbl%0d mem txns", i), 256'(txn_q.size()), 256'(tbl[i].ntx));
      if (tbl[i].ntx == 2 && txn_q.size() == 2) begin
        check($sformatf("tbl%0d wb write", i), 256'(txn_q[0].wr), 256'(1));
        check($sformatf("tbl%0d wb addr", i), 256'(txn_q[0].addr), 256'(tbl[i].wb_addr));
        check($sformatf("tbl%0d wb word", i), 256'(txn_q[0].data[tbl[i].wb_w*32 +: 32]),
              256'(tbl[i].wb_word));
      end
      if (tbl[i].ntx >= 1 && txn_q.size() == tbl[i].ntx) begin
        check($sformatf("tbl%0d rf write", i), 256'(txn_q[$].wr), 256'(0));
        check($sformatf("tbl%0d rf addr", i), 256'(txn_q[$].addr), 256'(tbl[i].rf_addr));
      end
    end

    // Reset in the middle of a refill abandons it and invalidates the cache.
    lat        = 3;
    cpu_rd_i   = 1'b1;
    cpu_addr_i = 32'h200;
    #1;
    check("abort miss stall", 256'(cpu_stall_o), 256'(1));
    repeat (2) @(negedge clk_i);
    #1;
    check("abort rf enable", 256'(mem_enable_o), 256'(1));
    check("abort rf write", 256'(mem_write_o), 256'(0));
    check("abort rf addr", 256'(mem_addr_o), 256'(32'h200));
    rst_i = 1'b0;
    #1;
    check("abort enable drop", 256'(mem_enable_o), 256'(0));
    check("abort stall drop", 256'(cpu_stall_o), 256'(0));
    @(negedge clk_i);
    rst_i    = 1'b1;
    cpu_rd_i = 1'b0;
    @(negedge clk_i);
    do_access(1'b1, 1'b0, 32'h104, 32'h0, cyc, rdata);
    check("post-rst miss cycles", 256'(cyc), 256'(4));
    check("post-rst data", 256'(rdata), 256'(32'hAAAA_5555));
    check("post-rst txns", 256'(txn_q.size()), 256'(1));

    // Randomized traffic on indices 0..7, tags 4..7; none of these lines were touched above.
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 5);
      if (op == 0) begin
        cpu_rd_i = 1'b0;
        cpu_wr_i = 1'b0;
        cpu_addr_i = $urandom;
        #1;
        check($sformatf("rnd%0d idle stall", n), 256'(cpu_stall_o), 256'(0));
        check($sformatf("rnd%0d idle data", n), 256'(cpu_data_o), 256'(0));
        check($sformatf("rnd%0d idle enable", n), 256'(mem_enable_o), 256'(0));
        @(negedge clk_i);
      end else begin
        rd    = (op != 4);
        wr    = (op >= 4);
        addr  = (32'(4 + $urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 5) |
                32'($urandom_range(0, 31));
        wdata = $urandom;
        lat   = $urandom_range(1, 4);
        model_access(wr, addr, wdata, exp_cyc, exp_data);
        do_access(rd, wr, addr, wdata, cyc, rdata);
        check($sformatf("rnd%0d cycles", n), 256'(cyc), 256'(exp_cyc));
        check($sformatf("rnd%0d data", n), 256'(rdata), 256'(exp_data));
        check($sformatf("rnd%0d txns", n), 256'(txn_q.size()), 256'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && j < txn_q.size(); j++) begin
          check($sformatf("rnd%0d txn%0d write", n, j), 256'(txn_q[j].wr), 256'(exp_q[j].wr));
          check($sformatf("rnd%0d txn%0d addr", n, j), 256'(txn_q[j].addr), 256'(exp_q[j].addr));
          if (exp_q[j].wr)
            check($sformatf("rnd%0d txn%0d line", n, j), txn_q[j].data, exp_q[j].data);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
